// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// All glyphs are active-low, bit order {g,f,e,d,c,b,a}.
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0     = 7'b1000000;
  localparam seg_t GLYPH_1     = 7'b1111001;
  localparam seg_t GLYPH_2     = 7'b0100100;
  localparam seg_t GLYPH_3     = 7'b0110000;
  localparam seg_t GLYPH_4     = 7'b0011001;
  localparam seg_t GLYPH_5     = 7'b0010010;
  localparam seg_t GLYPH_6     = 7'b0000010;
  localparam seg_t GLYPH_7     = 7'b1111000;
  localparam seg_t GLYPH_8     = 7'b0000000;
  localparam seg_t GLYPH_9     = 7'b0010000;
  localparam seg_t GLYPH_C     = 7'b1000110;
  localparam seg_t GLYPH_F     = 7'b0001110;
  localparam seg_t GLYPH_DASH  = 7'b0111111;
  localparam seg_t GLYPH_BLANK = 7'b1111111;

  localparam logic [1:0] DIG_UNIT = 2'd0;
  localparam logic [1:0] DIG_ONES = 2'd1;
  localparam logic [1:0] DIG_TENS = 2'd2;
  localparam logic [1:0] DIG_HUND = 2'd3;

  // One frame's worth of displayed state, captured atomically.
  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       unit_sel;
    logic       blank_en;
  } frame_t;

  localparam frame_t FRAME_RESET = '{hundreds: 4'd0, tens: 4'd0, ones: 4'd0,
                                     unit_sel: 1'b0, blank_en: 1'b1};

endpackage

// File: rtl/bcd_to_sseg.sv
// Combinational BCD digit to active-low segment decoder.
// Non-decimal codes decode to a dash; the blank flag overrides everything.
module bcd_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output seg_t       seg
);

  always_comb begin
    // NOTE: assigning a default first means every path drives seg, so no latch is inferred.
    seg = GLYPH_DASH;
    if (blank) begin
      seg = GLYPH_BLANK;
    end else begin
      case (value)
        4'd0:    seg = GLYPH_0;
        4'd1:    seg = GLYPH_1;
        4'd2:    seg = GLYPH_2;
        4'd3:    seg = GLYPH_3;
        4'd4:    seg = GLYPH_4;
        4'd5:    seg = GLYPH_5;
        4'd6:    seg = GLYPH_6;
        4'd7:    seg = GLYPH_7;
        4'd8:    seg = GLYPH_8;
        4'd9:    seg = GLYPH_9;
        default: seg = GLYPH_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit common-anode driver: unit letter plus three BCD digits,
// inputs captured once per frame, optional leading-zero blanking.
module seven_seg_scan
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ones,
  input  logic [3:0] tens,
  input  logic [3:0] hundreds,
  input  logic       unit_sel,
  input  logic       blank_en,
  output logic [3:0] an,
  output logic [6:0] sseg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div_cnt;
  logic [1:0]       idx;
  frame_t           shadow;

  logic             step;
  logic             capture;
  logic [3:0]       digit_val;
  logic             digit_blank;
  seg_t             dec_seg;
  seg_t             next_seg;
  logic [3:0]       next_an;

  assign step    = (div_cnt == DIV_LAST);
  // Capturing on the 3->0 wrap keeps every digit of a frame on the same snapshot.
  assign capture = step && (idx == DIG_HUND);

  always_comb begin
    digit_val   = shadow.ones;
    digit_blank = 1'b0;
    case (idx)
      DIG_ONES: digit_val = shadow.ones;
      DIG_TENS: begin
        digit_val   = shadow.tens;
        digit_blank = shadow.blank_en && (shadow.hundreds == 4'd0) && (shadow.tens == 4'd0);
      end
      DIG_HUND: begin
        digit_val   = shadow.hundreds;
        digit_blank = shadow.blank_en && (shadow.hundreds == 4'd0);
      end
      default: digit_val = shadow.ones;
    endcase
  end

  bcd_to_sseg u_dec (
    .value (digit_val),
    .blank (digit_blank),
    .seg   (dec_seg)
  );

  always_comb begin
    next_seg = dec_seg;
    if (idx == DIG_UNIT) begin
      next_seg = shadow.unit_sel ? GLYPH_F : GLYPH_C;
    end
    next_an = ~(4'b0001 << idx);
  end

  always_ff @(posedge clk) begin
    // NOTE: shadow registers are ordinary flops, so they are reset along with the
    // counters; the blanking default must be valid before the first capture.
    if (reset) begin
      div_cnt    <= '0;
      idx        <= DIG_UNIT;
      shadow     <= FRAME_RESET;
      frame_tick <= 1'b0;
      an         <= 4'b1111;
      sseg       <= GLYPH_BLANK;
    end else begin
      // NOTE: non-blocking assignments let an/sseg sample the pre-edge idx and shadow,
      // which is what gives the clean one-cycle output latency.
      div_cnt    <= step ? '0 : div_cnt + 1'b1;
      if (step) begin
        idx <= idx + 2'd1;
      end
      if (capture) begin
        shadow <= '{hundreds: hundreds, tens: tens, ones: ones,
                    unit_sel: unit_sel, blank_en: blank_en};
      end
      frame_tick <= capture;
      an         <= next_an;
      sseg       <= next_seg;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with REFRESH_DIV = 4 (16-cycle frames).
// Outputs are sampled on the falling edge; sample n after a tick or reset release is cycle n.
module tb_seven_seg_scan;

  localparam int RD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ones = 4'd0;
  logic [3:0] tens = 4'd0;
  logic [3:0] hundreds = 4'd0;
  logic       unit_sel = 1'b0;
  logic       blank_en = 1'b1;
  logic [3:0] an;
  logic [6:0] sseg;
  logic       dp;
  logic       frame_tick;

  int errors = 0;
  int checks = 0;

  logic [3:0] an_of [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  seven_seg_scan #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .reset      (reset),
    .ones       (ones),
    .tens       (tens),
    .hundreds   (hundreds),
    .unit_sel   (unit_sel),
    .blank_en   (blank_en),
    .an         (an),
    .sseg       (sseg),
    .dp         (dp),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111 || dp !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: an=%b sseg=%b dp=%b tick=%b, expected 1111/1111111/1/0",
               an, sseg, dp, frame_tick);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || sseg !== 7'b1000110) begin
      errors++;
      $display("FAIL first_after_reset: an=%b sseg=%b, expected 1110/1000110", an, sseg);
    end
  endtask

  task automatic test_digits();
    logic [6:0] exp_seg [4] = '{7'b0001110, 7'b0010010, 7'b0010010, 7'b0100100};
    int n = 0;
    hundreds = 4'd2; tens = 4'd5; ones = 4'd5; unit_sel = 1'b1; blank_en = 1'b1;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL digits_tick_timeout: no frame_tick within %0d cycles", n);
    end
    for (int k = 0; k < 4 * RD; k++) begin
      @(negedge clk);
      checks++;
      if (an !== an_of[k / RD] || sseg !== exp_seg[k / RD]) begin
        errors++;
        $display("FAIL digits_cycle%0d: an=%b sseg=%b, expected %b/%b",
                 k, an, sseg, an_of[k / RD], exp_seg[k / RD]);
      end
      checks++;
      if (frame_tick !== (k == 4 * RD - 1)) begin
        errors++;
        $display("FAIL digits_tick_cycle%0d: frame_tick=%b, expected %b",
                 k, frame_tick, (k == 4 * RD - 1));
      end
    end
  endtask

  task automatic test_blanking(input logic be, input logic [6:0] exp_lead);
    logic [6:0] exp_seg [4];
    int n = 0;
    exp_seg = '{7'b1000110, 7'b1111000, exp_lead, exp_lead};
    hundreds = 4'd0; tens = 4'd0; ones = 4'd7; unit_sel = 1'b0; blank_en = be;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL blank%0b_tick_timeout: no frame_tick within %0d cycles", be, n);
    end
    for (int k = 0; k < 4 * RD; k++) begin
      @(negedge clk);
      checks++;
      if (an !== an_of[k / RD] || sseg !== exp_seg[k / RD]) begin
        errors++;
        $display("FAIL blank%0b_cycle%0d: an=%b sseg=%b, expected %b/%b",
                 be, k, an, sseg, an_of[k / RD], exp_seg[k / RD]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [6:0] exp_seg [4] = '{7'b0001110, 7'b0110000, 7'b0111111, 7'b1111111};
    int n = 0;
    hundreds = 4'd0; tens = 4'hA; ones = 4'd3; unit_sel = 1'b1; blank_en = 1'b1;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL invalid_tick_timeout: no frame_tick within %0d cycles", n);
    end
    for (int k = 0; k < 4 * RD; k++) begin
      @(negedge clk);
      checks++;
      if (an !== an_of[k / RD] || sseg !== exp_seg[k / RD]) begin
        errors++;
        $display("FAIL invalid_cycle%0d: an=%b sseg=%b, expected %b/%b",
                 k, an, sseg, an_of[k / RD], exp_seg[k / RD]);
      end
    end
  endtask

  task automatic test_mid_frame();
    logic [6:0] old_seg [4] = '{7'b1000110, 7'b0110000, 7'b0100100, 7'b1111001};
    logic [6:0] new_seg [4] = '{7'b0001110, 7'b0011001, 7'b0000000, 7'b0010000};
    logic [6:0] exp;
    int n = 0;
    hundreds = 4'd1; tens = 4'd2; ones = 4'd3; unit_sel = 1'b0; blank_en = 1'b0;
    do begin @(negedge clk); n++; end while (frame_tick !== 1'b1 && n < 40);
    checks++;
    if (frame_tick !== 1'b1) begin
      errors++;
      $display("FAIL mid_tick_timeout: no frame_tick within %0d cycles", n);
    end
    for (int k = 0; k < 8 * RD; k++) begin
      @(negedge clk);
      exp = (k < 4 * RD) ? old_seg[(k / RD) % 4] : new_seg[(k / RD) % 4];
      checks++;
      if (an !== an_of[(k / RD) % 4] || sseg !== exp) begin
        errors++;
        $display("FAIL mid_cycle%0d: an=%b sseg=%b, expected %b/%b",
                 k, an, sseg, an_of[(k / RD) % 4], exp);
      end
      checks++;
      if (frame_tick !== ((k % (4 * RD)) == 4 * RD - 1)) begin
        errors++;
        $display("FAIL mid_tick_cycle%0d: frame_tick=%b, expected %b",
                 k, frame_tick, ((k % (4 * RD)) == 4 * RD - 1));
      end
      if (k == 6) begin
        hundreds = 4'd9; tens = 4'd8; ones = 4'd4; unit_sel = 1'b1;
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    logic [6:0] exp_seg [4] = '{7'b1000110, 7'b1000000, 7'b1111111, 7'b1111111};
    // Entered on the tick cycle; nine cycles later idx is 2 and the tens anode is lit.
    repeat (2 * RD + 1) @(negedge clk);
    checks++;
    if (an !== 4'b1011) begin
      errors++;
      $display("FAIL rst_mid_pre: an=%b, expected 1011", an);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'b1111 || sseg !== 7'b1111111 || dp !== 1'b1 || frame_tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: an=%b sseg=%b dp=%b tick=%b, expected 1111/1111111/1/0",
               an, sseg, dp, frame_tick);
    end
    reset = 1'b0;
    for (int k = 0; k < 4 * RD; k++) begin
      @(negedge clk);
      checks++;
      if (an !== an_of[k / RD] || sseg !== exp_seg[k / RD]) begin
        errors++;
        $display("FAIL rst_mid_cycle%0d: an=%b sseg=%b, expected %b/%b",
                 k, an, sseg, an_of[k / RD], exp_seg[k / RD]);
      end
      checks++;
      if (frame_tick !== (k == 4 * RD - 1)) begin
        errors++;
        $display("FAIL rst_mid_tick_cycle%0d: frame_tick=%b, expected %b",
                 k, frame_tick, (k == 4 * RD - 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_blanking(1'b1, 7'b1111111);
    test_blanking(1'b0, 7'b1000000);
    test_invalid();
    test_mid_frame();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
